// File: rtl/step_pulse_gen_pkg.sv
// Shared types and default constants for the multi-channel step pulse generator.
// The state enum is used by every channel instance.
package step_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_STEP  = 2'd2,
        ST_DONE  = 2'd3
    } step_state_e;

    localparam int NUM_CH_DEF     = 2;
    localparam int CNT_W_DEF      = 16;
    localparam int STEP_W_DEF     = 8;
    localparam int PERIOD_DEF_VAL = 5;

endpackage

// File: rtl/step_pulse_gen_channel.sv
// One independent step channel: SP edge detect, period counter, step counter and
// the IDLE/COUNT/STEP/DONE sequencer. Outputs are decoded from the state register.
module step_channel
    import step_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int STEP_W     = STEP_W_DEF,
    parameter int PERIOD_DEF = PERIOD_DEF_VAL
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              i_sp,
    input  logic              i_abort,
    input  logic              i_mode,
    input  logic [CNT_W-1:0]  i_period,
    input  logic [STEP_W-1:0] i_num_steps,
    output logic              o_step,
    output logic              o_busy,
    output logic              o_done
);

    step_state_e       r_state;
    step_state_e       w_state_nx;
    logic              r_sp_prev;
    logic              r_sp_armed;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nx;
    logic [CNT_W-1:0]  r_period;
    logic [CNT_W-1:0]  w_period_nx;
    logic [STEP_W-1:0] r_steps;
    logic [STEP_W-1:0] w_steps_nx;
    logic [STEP_W-1:0] r_nsteps;
    logic [STEP_W-1:0] w_nsteps_nx;
    logic              r_mode;
    logic              w_mode_nx;
    logic              r_stop;
    logic              w_stop_nx;
    logic              w_trig;
    logic              w_last_step;
    logic [CNT_W-1:0]  w_period_eff;

    function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v);
        sat_inc = (v == {STEP_W{1'b1}}) ? v : v + STEP_W'(1);
    endfunction

    // A trigger needs SP seen low since reset, so SP held high across reset is ignored.
    assign w_trig       = i_sp & ~r_sp_prev & r_sp_armed;
    assign w_period_eff = (i_period < CNT_W'(2)) ? CNT_W'(PERIOD_DEF) : i_period;
    assign w_last_step  = r_mode ? r_stop : (r_steps >= r_nsteps);

    // SP history and arming.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_sp_prev  <= 1'b0;
            r_sp_armed <= 1'b0;
        end else begin
            r_sp_prev  <= i_sp;
            r_sp_armed <= r_sp_armed | ~i_sp;
        end
    end

    // State and latched-field registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_period <= '0;
            r_steps  <= '0;
            r_nsteps <= '0;
            r_mode   <= 1'b0;
            r_stop   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_period <= w_period_nx;
            r_steps  <= w_steps_nx;
            r_nsteps <= w_nsteps_nx;
            r_mode   <= w_mode_nx;
            r_stop   <= w_stop_nx;
        end
    end

    // Next-state logic; the period counter restarts at each STEP so steps land every P cycles.
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_period_nx = r_period;
        w_steps_nx  = r_steps;
        w_nsteps_nx = r_nsteps;
        w_mode_nx   = r_mode;
        w_stop_nx   = r_stop;
        case (r_state)
            ST_IDLE: begin
                if (w_trig && !i_abort) begin
                    w_period_nx = w_period_eff;
                    w_nsteps_nx = i_num_steps;
                    w_mode_nx   = i_mode;
                    w_cnt_nx    = '0;
                    w_steps_nx  = '0;
                    w_stop_nx   = 1'b0;
                    if (!i_mode && (i_num_steps == STEP_W'(0))) begin
                        w_state_nx = ST_DONE;
                    end else begin
                        w_state_nx = ST_COUNT;
                    end
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (i_abort) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_stop_nx = r_stop | (w_trig & r_mode);
                    if (r_cnt >= (r_period - CNT_W'(1))) begin
                        w_state_nx = ST_STEP;
                        w_cnt_nx   = '0;
                        w_steps_nx = sat_inc(r_steps);
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_STEP: begin
                if (i_abort) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_stop_nx = r_stop | (w_trig & r_mode);
                    w_cnt_nx  = CNT_W'(1);
                    if (w_last_step) begin
                        w_state_nx = ST_DONE;
                    end else begin
                        w_state_nx = ST_COUNT;
                    end
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    assign o_step = (r_state == ST_STEP);
    assign o_busy = (r_state != ST_IDLE);
    assign o_done = (r_state == ST_DONE);

endmodule

// File: rtl/step_pulse_gen.sv
// Multi-channel step pulse generator: NUM_CH independent channels sharing
// PERIOD, NUM_STEPS and MODE, each with its own SP/ABORT and outputs.
module step_pulse_gen
    import step_pkg::*;
#(
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int STEP_W     = STEP_W_DEF,
    parameter int PERIOD_DEF = PERIOD_DEF_VAL
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [NUM_CH-1:0] SP,
    input  logic [NUM_CH-1:0] ABORT,
    input  logic              MODE,
    input  logic [CNT_W-1:0]  PERIOD,
    input  logic [STEP_W-1:0] NUM_STEPS,
    output logic [NUM_CH-1:0] STEP,
    output logic [NUM_CH-1:0] BUSY,
    output logic [NUM_CH-1:0] DONE
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        step_channel #(
            .CNT_W      (CNT_W),
            .STEP_W     (STEP_W),
            .PERIOD_DEF (PERIOD_DEF)
        ) u_ch (
            .CLK         (CLK),
            .RSTn        (RSTn),
            .i_sp        (SP[g]),
            .i_abort     (ABORT[g]),
            .i_mode      (MODE),
            .i_period    (PERIOD),
            .i_num_steps (NUM_STEPS),
            .o_step      (STEP[g]),
            .o_busy      (BUSY[g]),
            .o_done      (DONE[g])
        );
    end

endmodule
